// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the EX/MEM pipeline boundary:
// opcode constants, flag bit positions and the stage state encoding.
package ex_mem_stage_pkg;

   localparam logic [3:0] OP_ADD    = 4'b0000;
   localparam logic [3:0] OP_SUB    = 4'b0001;
   localparam logic [3:0] OP_XOR    = 4'b0010;
   localparam logic [3:0] OP_RED    = 4'b0011;
   localparam logic [3:0] OP_SLL    = 4'b0100;
   localparam logic [3:0] OP_SRA    = 4'b0101;
   localparam logic [3:0] OP_ROR    = 4'b0110;
   localparam logic [3:0] OP_PADDSB = 4'b0111;
   localparam logic [3:0] OP_HLT    = 4'b1111;

   // Bit positions inside the {Z,V,N} flag vector
   localparam int FLAG_Z = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_N = 0;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_e;

   function automatic logic is_hlt(input logic [3:0] op);
      return (op == OP_HLT);
   endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// Bundle of EX-side inputs and MEM-side outputs of the EX/MEM boundary.
// master = the surrounding pipeline, slave = the ex_mem_stage block.
interface ex_mem_stage_if #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 4,
   parameter int OP_W   = 4
);
   logic              ex_valid;
   logic              stall;
   logic              flush;
   logic [OP_W-1:0]   ex_opcode;
   logic [DATA_W-1:0] ex_result;
   logic              ex_ovf;
   logic [DATA_W-1:0] ex_store_data;
   logic [REG_AW-1:0] ex_rd;
   logic              ex_reg_write;
   logic              ex_mem_read;
   logic              ex_mem_write;

   logic              mem_valid;
   logic [DATA_W-1:0] mem_result;
   logic [DATA_W-1:0] mem_store_data;
   logic [REG_AW-1:0] mem_rd;
   logic              mem_reg_write;
   logic              mem_mem_read;
   logic              mem_mem_write;
   logic [2:0]        flags;
   logic              halted;
   logic              fwd_valid;
   logic [REG_AW-1:0] fwd_rd;
   logic [DATA_W-1:0] fwd_data;

   modport master (
      output ex_valid, stall, flush, ex_opcode, ex_result, ex_ovf,
             ex_store_data, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write,
      input  mem_valid, mem_result, mem_store_data, mem_rd, mem_reg_write,
             mem_mem_read, mem_mem_write, flags, halted,
             fwd_valid, fwd_rd, fwd_data
   );

   modport slave (
      input  ex_valid, stall, flush, ex_opcode, ex_result, ex_ovf,
             ex_store_data, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write,
      output mem_valid, mem_result, mem_store_data, mem_rd, mem_reg_write,
             mem_mem_read, mem_mem_write, flags, halted,
             fwd_valid, fwd_rd, fwd_data
   );

endinterface

// File: rtl/ex_mem_stage_flag_reg.sv
// Architectural {Z,V,N} flag register. cap_i strobes an update for a real
// instruction; the opcode selects which flags are rewritten, the rest hold.
module flag_reg
   import ex_mem_stage_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int OP_W   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cap_i,
   input  logic [OP_W-1:0]   op_i,
   input  logic [DATA_W-1:0] result_i,
   input  logic              ovf_i,
   output logic [2:0]        flags_o
);

   logic [2:0] flags_q;
   logic [2:0] flags_d;
   logic       zero;

   assign zero = (result_i == '0);

   // Next flag value: ADD/SUB rewrite all, logic/shift ops rewrite Z only
   always_comb begin
      flags_d = flags_q;
      if (cap_i) begin
         case (op_i)
            OP_ADD, OP_SUB: begin
               flags_d[FLAG_Z] = zero;
               flags_d[FLAG_V] = ovf_i;
               flags_d[FLAG_N] = result_i[DATA_W-1];
            end
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: begin
               flags_d[FLAG_Z] = zero;
            end
            default: begin
               flags_d = flags_q;
            end
         endcase
      end
   end

   // Flag storage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q <= 3'b000;
      end else begin
         flags_q <= flags_d;
      end
   end

   assign flags_o = flags_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with flag register and sticky halt.
// Optional MEM-stage forwarding port is built when EXMEM_FWD_EN is defined;
// otherwise the fwd_* outputs are tied low.
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_RUN     | normal operation: capture / stall / flush each edge
// ST_HALTED  | HLT captured; all state frozen until rst_n asserts
module ex_mem_stage
   import ex_mem_stage_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int REG_AW = 4,
   parameter int OP_W   = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   ex_mem_stage_if.slave  bus
);

   state_e            state_q;
   logic              valid_q;
   logic [DATA_W-1:0] result_q;
   logic [DATA_W-1:0] store_data_q;
   logic [REG_AW-1:0] rd_q;
   logic              reg_write_q;
   logic              mem_read_q;
   logic              mem_write_q;

   logic              capture;
   logic              ex_hlt;
   logic              flag_cap;

   // A capture edge only happens while running, with no flush and no stall
   assign capture  = (state_q == ST_RUN) && !bus.flush && !bus.stall;
   assign ex_hlt   = is_hlt(bus.ex_opcode);
   assign flag_cap = capture && bus.ex_valid;

   // Stage FSM and EX/MEM register; flush squashes control but keeps data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_RUN;
         valid_q      <= 1'b0;
         result_q     <= '0;
         store_data_q <= '0;
         rd_q         <= '0;
         reg_write_q  <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (bus.flush) begin
                  valid_q     <= 1'b0;
                  reg_write_q <= 1'b0;
                  mem_read_q  <= 1'b0;
                  mem_write_q <= 1'b0;
               end else if (!bus.stall) begin
                  valid_q      <= bus.ex_valid;
                  result_q     <= bus.ex_result;
                  store_data_q <= bus.ex_store_data;
                  rd_q         <= bus.ex_rd;
                  // HLT travels down the pipe as a valid no-op
                  reg_write_q  <= bus.ex_valid && bus.ex_reg_write && !ex_hlt;
                  mem_read_q   <= bus.ex_valid && bus.ex_mem_read  && !ex_hlt;
                  mem_write_q  <= bus.ex_valid && bus.ex_mem_write && !ex_hlt;
                  if (bus.ex_valid && ex_hlt) begin
                     state_q <= ST_HALTED;
                  end
               end
            end
            ST_HALTED: begin
               state_q <= ST_HALTED;
            end
            default: begin
               state_q <= ST_RUN;
            end
         endcase
      end
   end

   flag_reg #(
      .DATA_W (DATA_W),
      .OP_W   (OP_W)
   ) u_flag_reg (
      .clk      (clk),
      .rst_n    (rst_n),
      .cap_i    (flag_cap),
      .op_i     (bus.ex_opcode),
      .result_i (bus.ex_result),
      .ovf_i    (bus.ex_ovf),
      .flags_o  (bus.flags)
   );

   assign bus.mem_valid      = valid_q;
   assign bus.mem_result     = result_q;
   assign bus.mem_store_data = store_data_q;
   assign bus.mem_rd         = rd_q;
   assign bus.mem_reg_write  = valid_q && reg_write_q;
   assign bus.mem_mem_read   = valid_q && mem_read_q;
   assign bus.mem_mem_write  = valid_q && mem_write_q;
   assign bus.halted         = (state_q == ST_HALTED);

`ifdef EXMEM_FWD_EN
   // Loads are excluded: their data is not known until after this stage
   assign bus.fwd_valid = valid_q && reg_write_q && (rd_q != '0) && !mem_read_q;
   assign bus.fwd_rd    = rd_q;
   assign bus.fwd_data  = result_q;
`else
   assign bus.fwd_valid = 1'b0;
   assign bus.fwd_rd    = '0;
   assign bus.fwd_data  = '0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: table of per-edge vectors fed through a scoreboard
// queue, plus hand sequences for asynchronous reset while halted / stalled.
module tb_ex_mem_stage;
   import ex_mem_stage_pkg::*;

   typedef struct packed {
      logic        v;
      logic        st;
      logic        fl;
      logic [3:0]  op;
      logic [15:0] res;
      logic        ovf;
      logic [15:0] sd;
      logic [3:0]  rd;
      logic        rw;
      logic        mr;
      logic        mw;
   } in_t;

   typedef struct packed {
      logic        v;
      logic [15:0] res;
      logic [15:0] sd;
      logic [3:0]  rd;
      logic        rw;
      logic        mr;
      logic        mw;
      logic [2:0]  fl;
      logic        h;
   } exp_t;

   localparam int NV = 20;

   logic clk;
   logic rst_n;
   int   n_assert;
   int   n_fail;

   in_t   vin [NV];
   exp_t  vex [NV];
   string vnm [NV];
   exp_t  exp_q [$];
   string nm_q  [$];

   ex_mem_stage_if bus ();

   ex_mem_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input in_t i);
      bus.ex_valid      = i.v;
      bus.stall         = i.st;
      bus.flush         = i.fl;
      bus.ex_opcode     = i.op;
      bus.ex_result     = i.res;
      bus.ex_ovf        = i.ovf;
      bus.ex_store_data = i.sd;
      bus.ex_rd         = i.rd;
      bus.ex_reg_write  = i.rw;
      bus.ex_mem_read   = i.mr;
      bus.ex_mem_write  = i.mw;
   endtask

   task automatic cmp_out(input string t, input exp_t e);
      logic        efv;
      logic [3:0]  efrd;
      logic [15:0] efd;
`ifdef EXMEM_FWD_EN
      efv  = e.v & e.rw & (e.rd != 4'd0) & ~e.mr;
      efrd = e.rd;
      efd  = e.res;
`else
      efv  = 1'b0;
      efrd = 4'd0;
      efd  = 16'd0;
`endif
      chk({t, ".mem_valid"},      32'(bus.mem_valid),      32'(e.v));
      chk({t, ".mem_result"},     32'(bus.mem_result),     32'(e.res));
      chk({t, ".mem_store_data"}, 32'(bus.mem_store_data), 32'(e.sd));
      chk({t, ".mem_rd"},         32'(bus.mem_rd),         32'(e.rd));
      chk({t, ".mem_reg_write"},  32'(bus.mem_reg_write),  32'(e.rw));
      chk({t, ".mem_mem_read"},   32'(bus.mem_mem_read),   32'(e.mr));
      chk({t, ".mem_mem_write"},  32'(bus.mem_mem_write),  32'(e.mw));
      chk({t, ".flags"},          32'(bus.flags),          32'(e.fl));
      chk({t, ".halted"},         32'(bus.halted),         32'(e.h));
      chk({t, ".fwd_valid"},      32'(bus.fwd_valid),      32'(efv));
      chk({t, ".fwd_rd"},         32'(bus.fwd_rd),         32'(efrd));
      chk({t, ".fwd_data"},       32'(bus.fwd_data),       32'(efd));
   endtask

   // One edge: drive at negedge, queue the expectation, compare after posedge
   task automatic step(input in_t i, input exp_t e, input string nm);
      exp_t  ee;
      string en;
      @(negedge clk);
      drive(i);
      exp_q.push_back(e);
      nm_q.push_back(nm);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         chk({nm, ".scoreboard_empty"}, 32'd0, 32'd1);
      end else begin
         ee = exp_q.pop_front();
         en = nm_q.pop_front();
         cmp_out(en, ee);
      end
   endtask

   initial begin
      exp_t zero_e;
      n_assert = 0;
      n_fail   = 0;
      zero_e   = '0;
      rst_n    = 1'b0;
      drive('0);

      //            v    st   fl   op      res       ovf  sd        rd    rw   mr   mw
      vin[0]  = '{1'b1,1'b0,1'b0,OP_ADD, 16'h0000,1'b0,16'hAAAA,4'd1, 1'b1,1'b0,1'b0};
      vin[1]  = '{1'b1,1'b0,1'b0,OP_SUB, 16'h8000,1'b1,16'h1111,4'd2, 1'b1,1'b0,1'b0};
      vin[2]  = '{1'b1,1'b0,1'b0,OP_XOR, 16'h0001,1'b0,16'h2222,4'd3, 1'b1,1'b0,1'b0};
      vin[3]  = '{1'b1,1'b0,1'b0,OP_RED, 16'h0000,1'b1,16'h3333,4'd4, 1'b1,1'b0,1'b0};
      vin[4]  = '{1'b1,1'b0,1'b0,OP_XOR, 16'h0000,1'b0,16'h4444,4'd3, 1'b1,1'b0,1'b0};
      vin[5]  = '{1'b1,1'b0,1'b0,OP_ADD, 16'h1234,1'b0,16'h5555,4'd5, 1'b1,1'b0,1'b0};
      vin[6]  = '{1'b1,1'b0,1'b0,4'h8,   16'h0040,1'b0,16'h6666,4'd5, 1'b1,1'b1,1'b0};
      vin[7]  = '{1'b1,1'b0,1'b0,4'h9,   16'h0042,1'b0,16'h5A5A,4'd0, 1'b0,1'b0,1'b1};
      vin[8]  = '{1'b1,1'b0,1'b0,OP_ADD, 16'h0000,1'b0,16'h7777,4'd0, 1'b1,1'b0,1'b0};
      vin[9]  = '{1'b0,1'b0,1'b0,OP_ADD, 16'hFFFF,1'b1,16'h8888,4'd10,1'b1,1'b1,1'b1};
      vin[10] = '{1'b1,1'b0,1'b0,OP_SRA, 16'h8001,1'b0,16'h9999,4'd6, 1'b1,1'b0,1'b0};
      vin[11] = '{1'b1,1'b1,1'b0,OP_ADD, 16'h0000,1'b1,16'hAAAA,4'd7, 1'b1,1'b1,1'b1};
      vin[12] = '{1'b1,1'b1,1'b0,OP_SUB, 16'h8000,1'b1,16'hBBBB,4'd8, 1'b0,1'b0,1'b1};
      vin[13] = '{1'b0,1'b1,1'b0,OP_XOR, 16'h0000,1'b0,16'hCCCC,4'd9, 1'b1,1'b0,1'b0};
      vin[14] = '{1'b1,1'b1,1'b1,OP_ADD, 16'h0000,1'b1,16'hDDDD,4'd11,1'b1,1'b0,1'b0};
      vin[15] = '{1'b1,1'b0,1'b0,OP_ADD, 16'hFFFE,1'b0,16'hEEEE,4'd7, 1'b1,1'b0,1'b0};
      vin[16] = '{1'b1,1'b0,1'b1,OP_ADD, 16'h0000,1'b1,16'h1357,4'd12,1'b1,1'b0,1'b0};
      vin[17] = '{1'b1,1'b0,1'b0,OP_HLT, 16'h0BAD,1'b1,16'h2468,4'd8, 1'b1,1'b1,1'b1};
      vin[18] = '{1'b1,1'b0,1'b0,OP_ADD, 16'h0000,1'b1,16'h1111,4'd3, 1'b1,1'b0,1'b0};
      vin[19] = '{1'b1,1'b0,1'b1,OP_SUB, 16'h0000,1'b0,16'h0000,4'd2, 1'b1,1'b0,1'b0};

      //            v    res       sd        rd    rw   mr   mw   flags   h
      vex[0]  = '{1'b1,16'h0000,16'hAAAA,4'd1, 1'b1,1'b0,1'b0,3'b100,1'b0};
      vex[1]  = '{1'b1,16'h8000,16'h1111,4'd2, 1'b1,1'b0,1'b0,3'b011,1'b0};
      vex[2]  = '{1'b1,16'h0001,16'h2222,4'd3, 1'b1,1'b0,1'b0,3'b011,1'b0};
      vex[3]  = '{1'b1,16'h0000,16'h3333,4'd4, 1'b1,1'b0,1'b0,3'b011,1'b0};
      vex[4]  = '{1'b1,16'h0000,16'h4444,4'd3, 1'b1,1'b0,1'b0,3'b111,1'b0};
      vex[5]  = '{1'b1,16'h1234,16'h5555,4'd5, 1'b1,1'b0,1'b0,3'b000,1'b0};
      vex[6]  = '{1'b1,16'h0040,16'h6666,4'd5, 1'b1,1'b1,1'b0,3'b000,1'b0};
      vex[7]  = '{1'b1,16'h0042,16'h5A5A,4'd0, 1'b0,1'b0,1'b1,3'b000,1'b0};
      vex[8]  = '{1'b1,16'h0000,16'h7777,4'd0, 1'b1,1'b0,1'b0,3'b100,1'b0};
      vex[9]  = '{1'b0,16'hFFFF,16'h8888,4'd10,1'b0,1'b0,1'b0,3'b100,1'b0};
      vex[10] = '{1'b1,16'h8001,16'h9999,4'd6, 1'b1,1'b0,1'b0,3'b000,1'b0};
      vex[11] = vex[10];
      vex[12] = vex[10];
      vex[13] = vex[10];
      vex[14] = '{1'b0,16'h8001,16'h9999,4'd6, 1'b0,1'b0,1'b0,3'b000,1'b0};
      vex[15] = '{1'b1,16'hFFFE,16'hEEEE,4'd7, 1'b1,1'b0,1'b0,3'b001,1'b0};
      vex[16] = '{1'b0,16'hFFFE,16'hEEEE,4'd7, 1'b0,1'b0,1'b0,3'b001,1'b0};
      vex[17] = '{1'b1,16'h0BAD,16'h2468,4'd8, 1'b0,1'b0,1'b0,3'b001,1'b1};
      vex[18] = vex[17];
      vex[19] = vex[17];

      vnm[0]  = "add_zero";     vnm[1]  = "sub_neg_ovf";  vnm[2]  = "xor_nonzero";
      vnm[3]  = "red_zero";     vnm[4]  = "xor_zero";     vnm[5]  = "add_fwd";
      vnm[6]  = "lw_rd5";       vnm[7]  = "sw";           vnm[8]  = "add_rd0";
      vnm[9]  = "bubble";       vnm[10] = "sra_nonzero";  vnm[11] = "stall_1";
      vnm[12] = "stall_2";      vnm[13] = "stall_3";      vnm[14] = "flush_with_stall";
      vnm[15] = "add_negative"; vnm[16] = "flush_only";   vnm[17] = "hlt";
      vnm[18] = "add_after_hlt"; vnm[19] = "flush_while_halted";

      #12;
      cmp_out("reset", zero_e);
      @(negedge clk);
      rst_n = 1'b1;

      for (int k = 0; k < NV; k++) begin
         step(vin[k], vex[k], vnm[k]);
      end

      // Asynchronous reset while halted, asserted away from any clock edge
      #2;
      rst_n = 1'b0;
      #1;
      cmp_out("reset_while_halted", zero_e);
      @(negedge clk);
      rst_n = 1'b1;

      // Back in RUN: capture works again, then reset in the middle of a stall
      step('{1'b1,1'b0,1'b0,OP_ADD,16'h0000,1'b0,16'h0F0F,4'd9,1'b1,1'b0,1'b0},
           '{1'b1,16'h0000,16'h0F0F,4'd9,1'b1,1'b0,1'b0,3'b100,1'b0}, "add_after_reset");
      step('{1'b1,1'b1,1'b0,OP_SUB,16'h8000,1'b1,16'hF0F0,4'd10,1'b1,1'b0,1'b0},
           '{1'b1,16'h0000,16'h0F0F,4'd9,1'b1,1'b0,1'b0,3'b100,1'b0}, "stall_before_reset");
      #2;
      rst_n = 1'b0;
      #1;
      cmp_out("reset_mid_stall", zero_e);
      @(negedge clk);
      rst_n = 1'b1;
      step('{1'b1,1'b0,1'b0,OP_ROR,16'h0000,1'b1,16'h00FF,4'd3,1'b1,1'b0,1'b0},
           '{1'b1,16'h0000,16'h00FF,4'd3,1'b1,1'b0,1'b0,3'b100,1'b0}, "ror_zero");
      step('{1'b1,1'b0,1'b0,OP_PADDSB,16'h0000,1'b1,16'h0001,4'd4,1'b1,1'b0,1'b0},
           '{1'b1,16'h0000,16'h0001,4'd4,1'b1,1'b0,1'b0,3'b100,1'b0}, "paddsb_hold");
      step('{1'b1,1'b0,1'b0,OP_SLL,16'h0100,1'b1,16'h0002,4'd5,1'b1,1'b0,1'b0},
           '{1'b1,16'h0100,16'h0002,4'd5,1'b1,1'b0,1'b0,3'b000,1'b0}, "sll_nonzero");

      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Pipeline boundary between execute and memory stages of the 16-bit processor.
- Captures the ALU result from the adder, reduction, shift and PADDSB units, together with destination and memory-control bits, into the EX/MEM register.
- Owns the architectural flag register (Z, V, N), updated per opcode.
- Detects HLT and holds the pipeline in a sticky halted state.

Parameters:
- DATA_W, 16, datapath width (ALU result, store data).
- REG_AW, 4, register-file address width.
- OP_W, 4, opcode width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  EX stage holds a real instruction.
- stall  in  1  hold EX/MEM contents (memory busy).
- flush  in  1  squash incoming instruction (branch mispredict).
- ex_opcode  in  OP_W  opcode of the EX instruction.
- ex_result  in  DATA_W  ALU result (includes the sign-extended RED sum).
- ex_ovf  in  1  signed overflow from the ADD/SUB adder.
- ex_store_data  in  DATA_W  rt value for SW.
- ex_rd  in  REG_AW  destination register.
- ex_reg_write  in  1  EX writes rd.
- ex_mem_read  in  1  LW.
- ex_mem_write  in  1  SW.
- mem_valid  out  1  MEM stage holds a real instruction.
- mem_result  out  DATA_W  registered result / memory address.
- mem_store_data  out  DATA_W  registered store data.
- mem_rd  out  REG_AW  registered rd.
- mem_reg_write  out  1  gated by mem_valid.
- mem_mem_read  out  1  gated by mem_valid.
- mem_mem_write  out  1  gated by mem_valid.
- flags  out  3  {Z,V,N}.
- halted  out  1  sticky halt.
- fwd_valid  out  1  forwarding hit available.
- fwd_rd  out  REG_AW  forwarding destination.
- fwd_data  out  DATA_W  forwarding value.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, flags=3'b000, state RUN.
- Latency: one cycle from EX inputs to mem_* outputs.
- Per-edge priority in RUN:
  - halted: ignore inputs, hold all.
  - flush: mem_valid<=0; mem_reg_write, mem_mem_read and mem_mem_write <=0; data fields hold.
  - stall: hold everything, including flags.
  - otherwise: capture all ex_* fields, and mem_valid<=ex_valid.
- Control outputs are forced 0 whenever the captured valid is 0.
- Flush and stall asserted together: flush wins.
- Flags update only on a capture edge with ex_valid=1:
  - ADD(0000), SUB(0001): Z=(ex_result==0), N=ex_result[15], V=ex_ovf.
  - XOR(0010), SLL(0100), SRA(0101), ROR(0110): Z only; V and N hold.
  - RED(0011), PADDSB(0111), all others: all flags hold.
- Flag values are visible the cycle after capture.
- State machine RUN -> HALTED on a capture edge with ex_valid=1 and ex_opcode=1111. The HLT itself is captured (mem_valid=1) with control bits 0. halted=1 from that edge until reset.
- HALTED is exited only by reset.
- Reset mid-stall or while halted returns to RUN with all outputs cleared.

Optional Feature:
- Macro EXMEM_FWD_EN.
- Defined:
  - fwd_valid = mem_valid & mem_reg_write & (mem_rd!=0) & ~mem_mem_read.
  - fwd_rd = mem_rd.
  - fwd_data = mem_result.
  - LW results are never forwarded from this stage.
- Undefined: fwd_valid, fwd_rd and fwd_data tied to 0. Ports remain present.

Decomposition:
- Shared package: opcode constants (OP_ADD through OP_HLT) and flag bit indices (FLAG_Z=2, FLAG_V=1, FLAG_N=0).
- One sub-module, flag_reg: holds Z/V/N, with opcode-decoded update enables and a capture strobe.

Test Plan:
- Reset release, then ADD with result 16'h0000, ovf=0 -> next cycle mem_valid=1, flags=3'b100.
- SUB with result 16'h8000, ovf=1, then XOR with result 16'h0001 -> flags 3'b011 then 3'b011 (Z=0 rewritten, V and N held).
- RED with result 16'h0000 after flags=3'b011 -> flags stay 3'b011; mem_result=16'h0000; mem_reg_write=1.
- stall=1 for 3 cycles with changing inputs -> mem_* and flags frozen. flush=1 together with stall -> mem_valid=0, mem_reg_write=0 next cycle.
- HLT (1111) captured -> halted=1 next cycle; a following ADD is ignored (mem_result unchanged); rst_n pulse -> halted=0, all outputs 0.
- With EXMEM_FWD_EN: ADD rd=5 result 16'h1234 -> fwd_valid=1, fwd_rd=5, fwd_data=16'h1234. LW rd=5, or rd=0 -> fwd_valid=0.
